// File: rtl/fetch_unit_if.sv
// Instruction-bus types and the request/response interface used by fetch_unit.
package fetch_unit_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;
endpackage

interface fetch_unit_if;
    import fetch_unit_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;

    modport master (output ireq, input iresp);
    modport slave  (input ireq, output iresp);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues instruction-bus requests and buffers one instruction.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / drop_cnt performance counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                clk,
    input  logic                reset,
    fetch_unit_if.master        ibus,
    output fetch_data_t         dataF,
    output logic                fetch_valid,
    input  logic                stall,
    input  logic                jump,
    input  logic [63:0]         jump_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]         fetch_cnt,
    output logic [31:0]         drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DROP
    } state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [63:0] pend_target, pend_n;
    logic [31:0] ibuf, ibuf_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            ibuf        <= '0;
            pend_target <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            ibuf        <= ibuf_n;
            pend_target <= pend_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ibuf_n  = ibuf;
        pend_n  = pend_target;
        case (state)
            IDLE: begin
                state_n = REQ;
                if (jump) pc_n = jump_target;
            end
            REQ: begin
                if (ibus.iresp.data_ok) begin
                    if (jump) begin
                        pc_n = jump_target;
                    end else begin
                        ibuf_n  = ibus.iresp.data;
                        state_n = HOLD;
                    end
                end else if (jump) begin
                    pend_n  = jump_target;
                    state_n = DROP;
                end
            end
            // pc keeps the in-flight address so the request stays stable until data_ok
            DROP: begin
                if (ibus.iresp.data_ok) begin
                    pc_n    = jump ? jump_target : pend_target;
                    state_n = REQ;
                end else if (jump) begin
                    pend_n = jump_target;
                end
            end
            HOLD: begin
                if (jump) begin
                    pc_n    = jump_target;
                    state_n = REQ;
                end else if (!stall) begin
                    pc_n    = pc + 64'd4;
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ibus.ireq.valid = (state == REQ) || (state == DROP);
    assign ibus.ireq.addr  = pc;
    assign fetch_valid     = (state == HOLD);
    assign dataF.pc        = pc;
    assign dataF.raw_instr = ibuf;

`ifdef FETCH_PERF_CNT_EN
    logic consume, discard;

    assign consume = (state == HOLD) && !jump && !stall;
    assign discard = ((state == REQ) && ibus.iresp.data_ok && jump) ||
                     ((state == DROP) && ibus.iresp.data_ok);

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (consume) fetch_cnt <= fetch_cnt + 64'd1;
            if (discard) drop_cnt  <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed redirect/stall/reset scenarios against a delay-programmable bus model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [63:0] jump_target = '0;
    fetch_data_t dataF;
    logic        fetch_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] fetch_cnt;
    logic [31:0] drop_cnt;
`endif

    fetch_unit_if ibus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .ibus       (ibus.master),
        .dataF      (dataF),
        .fetch_valid(fetch_valid),
        .stall      (stall),
        .jump       (jump),
        .jump_target(jump_target)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_req[$];
    fetch_data_t exp_fetch[$];
    int          bus_delay = 0;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] instr_of(logic [63:0] a);
        return a[31:0] ^ 32'h0000_0013;
    endfunction

    task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_req(logic [63:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_fetch(logic [63:0] a);
        fetch_data_t f;
        f.pc        = a;
        f.raw_instr = instr_of(a);
        exp_fetch.push_back(f);
    endtask

    // Bus slave: data_ok on the (bus_delay+1)-th cycle of each request; junk data otherwise
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        ibus.iresp = '0;
        forever begin
            @(negedge clk);
            if (ibus.ireq.valid !== 1'b1) begin
                wait_cnt           = 0;
                ibus.iresp.data_ok = 1'b0;
                ibus.iresp.data    = 32'hDEAD_BEEF;
            end else begin
                if (ibus.iresp.data_ok) wait_cnt = 0;
                ibus.iresp.data_ok = (wait_cnt == bus_delay);
                ibus.iresp.data    = ibus.iresp.data_ok ? instr_of(ibus.ireq.addr) : 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end
    end

    // Monitor: pops expected requests/fetches as the DUT presents them
    initial begin
        logic        prev_v, prev_fv;
        logic [63:0] prev_addr;
        fetch_data_t held, e;
        prev_v    = 1'b0;
        prev_fv   = 1'b0;
        prev_addr = '0;
        held      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) begin
                prev_v  = 1'b0;
                prev_fv = 1'b0;
            end else begin
                if (ibus.ireq.valid === 1'b1) begin
                    if (!prev_v || ibus.iresp.data_ok) begin
                        if (exp_req.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_req: got addr %h, required no request", ibus.ireq.addr);
                        end else begin
                            check64("req_addr", ibus.ireq.addr, exp_req.pop_front());
                        end
                    end else begin
                        check64("req_addr_stable", ibus.ireq.addr, prev_addr);
                    end
                end
                if (fetch_valid === 1'b1) begin
                    check64("hold_no_req", 64'(ibus.ireq.valid), 64'd0);
                    if (!prev_fv) begin
                        if (exp_fetch.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_fetch: got pc %h instr %h, required none", dataF.pc, dataF.raw_instr);
                        end else begin
                            e = exp_fetch.pop_front();
                            check64("fetch_pc", dataF.pc, e.pc);
                            check64("fetch_instr", 64'(dataF.raw_instr), 64'(e.raw_instr));
                        end
                        held = dataF;
                    end else begin
                        check64("hold_pc_stable", dataF.pc, held.pc);
                        check64("hold_instr_stable", 64'(dataF.raw_instr), 64'(held.raw_instr));
                    end
                end
                prev_v    = (ibus.ireq.valid === 1'b1);
                prev_addr = ibus.ireq.addr;
                prev_fv   = (fetch_valid === 1'b1);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_fetch(string name);
        int n;
        n = 0;
        while (fetch_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (fetch_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: fetch_valid=%b after %0d cycles, required 1", name, fetch_valid, n);
        end
    endtask

    task automatic check_reset_state(string name);
        check64({name, "_req_valid"}, 64'(ibus.ireq.valid), 64'd0);
        check64({name, "_req_addr"}, ibus.ireq.addr, RST_PC);
        check64({name, "_fetch_valid"}, 64'(fetch_valid), 64'd0);
        check64({name, "_pc"}, dataF.pc, RST_PC);
        check64({name, "_instr"}, 64'(dataF.raw_instr), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        check64({name, "_fetch_cnt"}, fetch_cnt, 64'd0);
        check64({name, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
`endif
    endtask

    initial begin
        // Reset
        step();
        check_reset_state("reset");

        // Zero-wait stream: 0x8000_0000, 0x8000_0004, stop stalled on the second
        push_req(64'h8000_0000);
        push_fetch(64'h8000_0000);
        push_req(64'h8000_0004);
        push_fetch(64'h8000_0004);
        reset  = 1'b1;
        mon_en = 1'b1;
        wait_fetch("first");
        step();
        wait_fetch("second");
        stall = 1'b1;

        // Stall 3 cycles in HOLD, then advance to 0x8000_0008
        repeat (3) step();
        push_req(64'h8000_0008);
        push_fetch(64'h8000_0008);
        stall = 1'b0;
        step();
        wait_fetch("after_stall");
        stall = 1'b1;

        // jump + stall in HOLD discards the buffered instruction
        push_req(64'h8000_0200);
        push_fetch(64'h8000_0200);
        jump        = 1'b1;
        jump_target = 64'h8000_0200;
        step();
        jump = 1'b0;
        wait_fetch("hold_jump");

        // 4-cycle bus delay with jump on the 2nd wait cycle
        bus_delay = 4;
        push_req(64'h8000_0204);
        push_req(64'h8000_0100);
        push_fetch(64'h8000_0100);
        stall = 1'b0;
        step();
        stall = 1'b1;
        step();
        jump        = 1'b1;
        jump_target = 64'h8000_0100;
        step();
        jump = 1'b0;
        wait_fetch("drop_jump");

        // Two jumps while dropping: latest target wins
        push_req(64'h8000_0104);
        push_req(64'h0000_0000_0000_0020);
        push_fetch(64'h0000_0000_0000_0020);
        stall = 1'b0;
        step();
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 64'h0000_0000_0000_0010;
        step();
        jump_target = 64'h0000_0000_0000_0020;
        step();
        jump = 1'b0;
        wait_fetch("double_jump");
`ifdef FETCH_PERF_CNT_EN
        check64("drop_cnt_after_drop", 64'(drop_cnt), 64'd2);
`endif

        // jump coinciding with data_ok in REQ on a zero-wait bus
        bus_delay = 0;
        push_req(64'h0000_0000_0000_0024);
        push_req(64'h0000_0000_0000_0300);
        push_fetch(64'h0000_0000_0000_0300);
        stall = 1'b0;
        step();
        stall       = 1'b1;
        jump        = 1'b1;
        jump_target = 64'h0000_0000_0000_0300;
        step();
        jump = 1'b0;
        wait_fetch("req_ok_jump");
`ifdef FETCH_PERF_CNT_EN
        check64("drop_cnt_req_ok", 64'(drop_cnt), 64'd3);
`endif

        // PC wraps at 64 bits
        push_req(64'hFFFF_FFFF_FFFF_FFFC);
        push_fetch(64'hFFFF_FFFF_FFFF_FFFC);
        push_req(64'h0);
        push_fetch(64'h0);
        jump        = 1'b1;
        jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        jump = 1'b0;
        wait_fetch("wrap_top");
        stall = 1'b0;
        step();
        stall = 1'b1;
        wait_fetch("wrap_zero");
`ifdef FETCH_PERF_CNT_EN
        check64("fetch_cnt", fetch_cnt, 64'd6);
`endif

        // Reset in the middle of a delayed request
        bus_delay = 4;
        push_req(64'h4);
        stall = 1'b0;
        step();
        step();
        reset  = 1'b0;
        mon_en = 1'b0;
        stall  = 1'b1;
        step();
        check_reset_state("mid_reset");
        step();

        // jump sampled in IDLE on the first cycle out of reset
        bus_delay = 0;
        push_req(64'h400);
        push_fetch(64'h400);
        jump        = 1'b1;
        jump_target = 64'h400;
        reset       = 1'b1;
        mon_en      = 1'b1;
        step();
        jump = 1'b0;
        wait_fetch("idle_jump");
        repeat (3) step();

        check64("req_queue_empty", 64'(exp_req.size()), 64'd0);
        check64("fetch_queue_empty", 64'(exp_fetch.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
